// File: rtl/adder_4_pkg.sv
// Shared types and constants for the registered nibble adder.
package adder_4_pkg;

  localparam int ADDER_4_W = 4;

  typedef logic [ADDER_4_W-1:0] nibble_t;

  // Full 5-bit add result: carry out of the top bit plus the nibble sum.
  typedef struct packed {
    logic    cout;
    nibble_t sum;
  } add_res_t;

endpackage

// File: rtl/adder_4_if.sv
// Operand/result bus for adder_4. The ovf signal exists only when
// ADDER_4_OVF_EN is defined.
//
// Handshake: in_valid qualifies a, b and cin in the cycle it is high, and the
// adder accepts every such cycle (there is no ready). out_valid is high for
// exactly the cycle after an accepted input and qualifies sum/cout/ovf.
interface adder_4_if;
  import adder_4_pkg::*;

  logic    in_valid;
  nibble_t a;
  nibble_t b;
  logic    cin;
  logic    out_valid;
  nibble_t sum;
  logic    cout;
`ifdef ADDER_4_OVF_EN
  logic    ovf;
`endif

  modport master (
    output in_valid, a, b, cin,
`ifdef ADDER_4_OVF_EN
    input  ovf,
`endif
    input  out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef ADDER_4_OVF_EN
    output ovf,
`endif
    output out_valid, sum, cout
  );

endinterface

// File: rtl/adder_4_full_adder_cell.sv
// One bit of the ripple chain: sum and carry from two operand bits and a
// carry in. Purely combinational.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared between sum and carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/adder_4.sv
// Registered 4-bit ripple-carry adder with carry in/out.
// Optional macro ADDER_4_OVF_EN adds a registered signed-overflow output.
module adder_4
  import adder_4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  adder_4_if.slave   bus
);

  logic [ADDER_4_W:0]   c;
  nibble_t              s;
  add_res_t             res;
  add_res_t             res_q;
  logic                 valid_q;

  assign c[0] = bus.cin;

  for (genvar i = 0; i < ADDER_4_W; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign res.cout = c[ADDER_4_W];
  assign res.sum  = s;

  // Capture the result on valid cycles; out_valid simply follows in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) res_q <= res;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.sum       = res_q.sum;
  assign bus.cout      = res_q.cout;

`ifdef ADDER_4_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               ovf_q <= 1'b0;
    else if (bus.in_valid) ovf_q <= c[ADDER_4_W-1] ^ c[ADDER_4_W];
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_4.sv
// Bench for adder_4: scoreboard of expected {ovf, cout, sum} fed by the
// driver, checked by a negedge monitor whenever out_valid is high, and a
// hold check whenever it is low.
module tb_adder_4;
  import adder_4_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [5:0] exp_q[$];
  logic [5:0] last_exp;

  adder_4_if bus ();

  adder_4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic ci);
    int u;
    int sa;
    int sb;
    int sr;
    logic o;
    logic [4:0] u5;
    u  = int'(a) + int'(b) + int'(ci);
    sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    sr = sa + sb + int'(ci);
    o  = (sr > 7) || (sr < -8);
`ifndef ADDER_4_OVF_EN
    o  = 1'b0;
`endif
    u5 = u[4:0];
    return {o, u5};
  endfunction

  function automatic logic [5:0] act_vec();
`ifdef ADDER_4_OVF_EN
    return {bus.ovf, bus.cout, bus.sum};
`else
    return {1'b0, bus.cout, bus.sum};
`endif
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act {ovf,cout,sum}=%b exp=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%b exp=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; a valid cycle queues its expected result.
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic ci);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    if (v) exp_q.push_back(model(a, b, ci));
  endtask

  // Monitor: pop on out_valid, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (rst) begin
      last_exp = '0;
    end else if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 6'h3f, 6'h00);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check("result", act_vec(), e);
        last_exp = e;
      end
    end else begin
      check_bit("out_valid_low", bus.out_valid, 1'b0);
      check("hold", act_vec(), last_exp);
    end
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    last_exp     = '0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", act_vec(), 6'h00);
    check_bit("reset_out_valid", bus.out_valid, 1'b0);
    rst = 1'b0;

    // Idle cycles after release: outputs stay zero (monitor hold check).
    drive(1'b0, 4'h3, 4'h4, 1'b1);
    drive(1'b0, 4'h3, 4'h4, 1'b1);

    // Directed cases, including wrap-around and signed overflow.
    drive(1'b1, 4'hA, 4'h5, 1'b0);
    drive(1'b1, 4'hF, 4'h1, 1'b0);
    drive(1'b1, 4'hF, 4'hF, 1'b1);
    drive(1'b1, 4'h7, 4'h8, 1'b1);
    drive(1'b1, 4'h7, 4'h1, 1'b0);
    drive(1'b0, 4'h2, 4'h2, 1'b1);
    drive(1'b0, 4'h9, 4'h9, 1'b0);

    // Exhaustive sweep of all operand/carry combinations.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v9;
      v9 = 9'(i);
      drive(1'b1, v9[8:5], v9[4:1], v9[0]);
    end

    // Random traffic with random gaps.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Mid-stream reset: the pending operand set must never emerge.
    drive(1'b1, 4'h6, 4'h6, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", act_vec(), 6'h00);
    check_bit("async_reset_out_valid", bus.out_valid, 1'b0);
    exp_q.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_bit("reset_held_out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 4'h1, 4'h1, 1'b0);
    drive(1'b1, 4'hC, 4'h3, 1'b1);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: act=%0d pending exp=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
